// File: rtl/iob_fifo_sync_asym_if.sv
// rtl/iob_fifo_sync_asym_if.sv - user-side write/read/level bundle for iob_fifo_sync_asym
// Almost flags appear only when IOB_FIFO_ALMOST_FLAGS_EN is defined.
interface iob_fifo_sync_asym_if #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
);
  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                w_full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_empty;
  logic [ADDR_W:0]     level;
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
  logic                almost_full;
  logic                almost_empty;

  modport master (
    output w_en, w_data, r_en,
    input  w_full, r_data, r_empty, level, almost_full, almost_empty
  );
  modport slave (
    input  w_en, w_data, r_en,
    output w_full, r_data, r_empty, level, almost_full, almost_empty
  );
`else
  modport master (
    output w_en, w_data, r_en,
    input  w_full, r_data, r_empty, level
  );
  modport slave (
    input  w_en, w_data, r_en,
    output w_full, r_data, r_empty, level
  );
`endif
endinterface

// File: rtl/iob_fifo_sync_asym.sv
// rtl/iob_fifo_sync_asym.sv - single-clock asymmetric-width FIFO over N external symmetric memory blocks
// Optional almost_full/almost_empty flags are enabled by defining IOB_FIFO_ALMOST_FLAGS_EN.
module iob_fifo_sync_asym #(
  parameter int W_DATA_W        = 32,
  parameter int R_DATA_W        = 8,
  parameter int ADDR_W          = 4,
  parameter int ALMOST_FULL_TH  = 2,
  parameter int ALMOST_EMPTY_TH = 2,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
  localparam int N         = MAXDATA_W / MINDATA_W,
  localparam int LOG_N     = $clog2(N),
  localparam int MINADDR_W = ADDR_W - LOG_N
) (
  input  logic                     clk,
  input  logic                     rst,
  iob_fifo_sync_asym_if.slave      bus,
  output logic [N-1:0]             ext_mem_w_en,
  output logic [MINADDR_W*N-1:0]   ext_mem_w_addr,
  output logic [MINDATA_W*N-1:0]   ext_mem_w_data,
  output logic                     ext_mem_r_en,
  output logic [MINADDR_W*N-1:0]   ext_mem_r_addr,
  input  logic [MINDATA_W*N-1:0]   ext_mem_r_data
);

  localparam int W_RATIO = W_DATA_W / MINDATA_W;
  localparam int R_RATIO = R_DATA_W / MINDATA_W;
  localparam int LOG_W   = $clog2(W_RATIO);
  localparam int LOG_R   = $clog2(R_RATIO);
  localparam int WPTR_W  = ADDR_W + 1 - LOG_W;
  localparam int RPTR_W  = ADDR_W + 1 - LOG_R;

  localparam logic [ADDR_W:0] FULL_LIM = (ADDR_W+1)'((1 << ADDR_W) - W_RATIO);
  localparam logic [ADDR_W:0] R_INC    = (ADDR_W+1)'(R_RATIO);

  logic [WPTR_W-1:0] wptr, wptr_next;
  logic [RPTR_W-1:0] rptr, rptr_next;
  logic [ADDR_W:0]   level_q, level_next;
  logic              w_full_q, r_empty_q;
  logic              wr_acc, rd_acc;

  assign wr_acc = bus.w_en & ~w_full_q;
  assign rd_acc = bus.r_en & ~r_empty_q;

  // Scaling both wrapping pointers to narrow-word units gives occupancy modulo
  // 2^(ADDR_W+1), identical to level + W_RATIO*wr_acc - R_RATIO*rd_acc.
  always_comb begin
    wptr_next  = wptr + WPTR_W'(wr_acc);
    rptr_next  = rptr + RPTR_W'(rd_acc);
    level_next = ((ADDR_W+1)'(wptr_next) << LOG_W) - ((ADDR_W+1)'(rptr_next) << LOG_R);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level_q   <= '0;
      w_full_q  <= 1'b0;
      r_empty_q <= 1'b1;
    end else begin
      wptr      <= wptr_next;
      rptr      <= rptr_next;
      level_q   <= level_next;
      w_full_q  <= (level_next > FULL_LIM);
      r_empty_q <= (level_next < R_INC);
    end
  end

  assign bus.level   = level_q;
  assign bus.w_full  = w_full_q;
  assign bus.r_empty = r_empty_q;

`ifdef IOB_FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_W:0] DEPTH  = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_LIM = (ADDR_W+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(ALMOST_EMPTY_TH);

  logic almost_full_q, almost_empty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= ((DEPTH - level_next) <= AF_LIM);
      almost_empty_q <= (level_next <= AE_LIM);
    end
  end

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`endif

  if (W_RATIO == N) begin : g_wide_wr
    for (genvar j = 0; j < N; j++) begin : g_lane
      assign ext_mem_w_en[j] = wr_acc;
      assign ext_mem_w_addr[j*MINADDR_W +: MINADDR_W] = wptr[MINADDR_W-1:0];
      assign ext_mem_w_data[j*MINDATA_W +: MINDATA_W] = bus.w_data[j*MINDATA_W +: MINDATA_W];
    end
  end else begin : g_narrow_wr
    // Consecutive narrow words rotate across blocks so a wide read sees them LSB-first.
    for (genvar j = 0; j < N; j++) begin : g_lane
      assign ext_mem_w_en[j] = wr_acc && (wptr[LOG_N-1:0] == LOG_N'(j));
      assign ext_mem_w_addr[j*MINADDR_W +: MINADDR_W] = wptr[ADDR_W-1:LOG_N];
      assign ext_mem_w_data[j*MINDATA_W +: MINDATA_W] = bus.w_data;
    end
  end

  assign ext_mem_r_en = rd_acc;

  if (R_RATIO == N) begin : g_wide_rd
    for (genvar j = 0; j < N; j++) begin : g_lane
      assign ext_mem_r_addr[j*MINADDR_W +: MINADDR_W] = rptr[MINADDR_W-1:0];
    end
    assign bus.r_data = ext_mem_r_data;
  end else begin : g_narrow_rd
    logic [LOG_N-1:0] lane_sel;

    // Lane select is aligned with the memory's registered read data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_sel <= '0;
      end else if (rd_acc) begin
        lane_sel <= rptr[LOG_N-1:0];
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
      assign ext_mem_r_addr[j*MINADDR_W +: MINADDR_W] = rptr[ADDR_W-1:LOG_N];
    end
    assign bus.r_data = ext_mem_r_data[lane_sel*MINDATA_W +: MINDATA_W];
  end

endmodule
